// File: rtl/cp0_registers_pkg.sv
// Shared CP0 definitions: bus widths, register numbers, ExcCode values and
// Status/Cause bit positions. The timer feature is gated by CP0_TIMER_EN.
package cp0_registers_pkg;

  localparam int DATA_W    = 32;
  localparam int CP0_REG_W = 5;

  localparam logic REG_WB = 1'b1;

  localparam logic [CP0_REG_W-1:0] CP0_BADVADDR = 5'd8;
  localparam logic [CP0_REG_W-1:0] CP0_COUNT    = 5'd9;
  localparam logic [CP0_REG_W-1:0] CP0_COMPARE  = 5'd11;
  localparam logic [CP0_REG_W-1:0] CP0_STATUS   = 5'd12;
  localparam logic [CP0_REG_W-1:0] CP0_CAUSE    = 5'd13;
  localparam logic [CP0_REG_W-1:0] CP0_EPC      = 5'd14;
  localparam logic [CP0_REG_W-1:0] CP0_PRID     = 5'd15;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;
  localparam logic [4:0] EXC_TR   = 5'd13;

  localparam int STATUS_CU0   = 28;
  localparam int STATUS_IM_HI = 15;
  localparam int STATUS_IM_LO = 8;
  localparam int STATUS_EXL   = 1;
  localparam int STATUS_IE    = 0;

  localparam int CAUSE_BD     = 31;
  localparam int CAUSE_IP_HI  = 15;
  localparam int CAUSE_HW_LO  = 10;
  localparam int CAUSE_SW_HI  = 9;
  localparam int CAUSE_SW_LO  = 8;
  localparam int CAUSE_EXC_HI = 6;
  localparam int CAUSE_EXC_LO = 2;

  localparam logic [DATA_W-1:0] STATUS_RESET = 32'h1000_0000;
  localparam logic [DATA_W-1:0] STATUS_WMASK = 32'h1000_FF03;

  // Address-error exceptions are the only ones that capture BadVAddr.
  function automatic logic is_addr_exc(input logic [4:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: free-running Count, software-writable Compare and a
// sticky timer_int flag cleared by any write to Compare.
module cp0_timer
  import cp0_registers_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              count_we,
  input  logic              compare_we,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] count,
  output logic [DATA_W-1:0] compare,
  output logic              timer_int
);

  logic match;

  assign match = (count == compare) && (compare != '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      compare   <= '0;
      timer_int <= 1'b0;
    end else begin
      count <= count_we ? wdata : count + 32'd1;
      if (compare_we) compare <= wdata;
      // A Compare write clears even when the match condition holds this cycle.
      if (compare_we)  timer_int <= 1'b0;
      else if (match)  timer_int <= 1'b1;
    end
  end

endmodule

// File: rtl/cp0_registers.sv
// CP0 register file: BadVAddr, Count, Compare, Status, Cause, EPC, PRId with
// exception/eret bookkeeping and interrupt request. Timer under CP0_TIMER_EN.
module cp0_registers
  import cp0_registers_pkg::*;
#(
  parameter logic [DATA_W-1:0] PRID = 32'h0001_8000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cp0_reg_rw,
  input  logic [CP0_REG_W-1:0] cp0_reg_write_addr,
  input  logic [DATA_W-1:0]    cp0_reg_write,
  input  logic [CP0_REG_W-1:0] cp0_reg_read_addr,
  output logic [DATA_W-1:0]    cp0_reg_read,
  input  logic                 exc_valid,
  input  logic [4:0]           exc_code,
  input  logic [DATA_W-1:0]    exc_pc,
  input  logic                 exc_bd,
  input  logic [DATA_W-1:0]    exc_badvaddr,
  input  logic                 eret,
  input  logic [5:0]           hw_int,
  output logic [DATA_W-1:0]    status,
  output logic [DATA_W-1:0]    cause,
  output logic [DATA_W-1:0]    epc,
  output logic                 int_req,
  output logic                 timer_int
);

  logic [DATA_W-1:0] badvaddr_q, status_q, cause_q, epc_q;
  logic [DATA_W-1:0] badvaddr_d, status_d, cause_d, epc_d;
  logic [DATA_W-1:0] count_val, compare_val;
  logic              timer_flag;
  logic              sw_we;

  assign sw_we = (cp0_reg_rw == REG_WB);

`ifdef CP0_TIMER_EN
  cp0_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .count_we   (sw_we && (cp0_reg_write_addr == CP0_COUNT)),
    .compare_we (sw_we && (cp0_reg_write_addr == CP0_COMPARE)),
    .wdata      (cp0_reg_write),
    .count      (count_val),
    .compare    (compare_val),
    .timer_int  (timer_flag)
  );
`else
  assign count_val   = '0;
  assign compare_val = '0;
  assign timer_flag  = 1'b0;
`endif

  // Software write first, then eret, then exception: later assignments win
  // only on the bits they touch.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is
    // inferred on paths that do not assign it.
    status_d   = status_q;
    cause_d    = cause_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;

    if (sw_we) begin
      unique case (cp0_reg_write_addr)
        CP0_STATUS: status_d = cp0_reg_write & STATUS_WMASK;
        CP0_CAUSE:  cause_d[CAUSE_SW_HI:CAUSE_SW_LO] = cp0_reg_write[CAUSE_SW_HI:CAUSE_SW_LO];
        CP0_EPC:    epc_d = cp0_reg_write;
        default:    ;
      endcase
    end

    cause_d[CAUSE_IP_HI:CAUSE_HW_LO] = hw_int;

    if (eret) status_d[STATUS_EXL] = 1'b0;

    if (exc_valid) begin
      status_d[STATUS_EXL]                = 1'b1;
      cause_d[CAUSE_EXC_HI:CAUSE_EXC_LO] = exc_code;
      // Nested exceptions keep the original return point.
      if (!status_q[STATUS_EXL]) begin
        cause_d[CAUSE_BD] = exc_bd;
        epc_d             = exc_bd ? exc_pc - 32'd4 : exc_pc;
      end
      if (is_addr_exc(exc_code)) badvaddr_d = exc_badvaddr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      badvaddr_q <= '0;
      status_q   <= STATUS_RESET;
      cause_q    <= '0;
      epc_q      <= '0;
    end else begin
      badvaddr_q <= badvaddr_d;
      status_q   <= status_d;
      cause_q    <= cause_d;
      epc_q      <= epc_d;
    end
  end

  // IP[15] is shared between hw_int[5] and the timer flag.
  always_comb begin
    cause = cause_q;
    cause[CAUSE_IP_HI] = cause_q[CAUSE_IP_HI] | timer_flag;
  end

  assign status    = status_q;
  assign epc       = epc_q;
  assign timer_int = timer_flag;

  assign int_req = status_q[STATUS_IE] & ~status_q[STATUS_EXL] &
                   (|(cause[CAUSE_IP_HI:CAUSE_SW_LO] & status_q[STATUS_IM_HI:STATUS_IM_LO]));

  always_comb begin
    cp0_reg_read = '0;
    unique case (cp0_reg_read_addr)
      CP0_BADVADDR: cp0_reg_read = badvaddr_q;
      CP0_COUNT:    cp0_reg_read = count_val;
      CP0_COMPARE:  cp0_reg_read = compare_val;
      CP0_STATUS:   cp0_reg_read = status_q;
      CP0_CAUSE:    cp0_reg_read = cause;
      CP0_EPC:      cp0_reg_read = epc_q;
      CP0_PRID:     cp0_reg_read = PRID;
      default:      cp0_reg_read = '0;
    endcase
  end

endmodule
